fifo_pop_streamer: RTL

FIFO_POP_STREAMER -- requirements
Module: fifo_pop_streamer

---
 rtl/fifo_pop_streamer_if.sv | 24 ++
 rtl/fifo_pop_streamer.sv | 108 ++++++++++
 2 files changed

// File: rtl/fifo_pop_streamer_if.sv
// Handshake bundle between the streamer, its upstream FWFT FIFO read port
// and the downstream beat sink.
interface fifo_pop_streamer_if;
  logic        fifoEmpty;
  logic [83:0] fifoDataOut;
  logic        fifoPop;
  logic        txValid;
  logic        txReady;
  logic [63:0] txData;
  logic [9:0]  txTag;
  logic [7:0]  txByteEn;
  logic        txEop;
  logic        txSop;

  modport master (
    input  fifoEmpty, fifoDataOut, txReady,
    output fifoPop, txValid, txData, txTag, txByteEn, txEop, txSop
  );

  modport slave (
    output fifoEmpty, fifoDataOut, txReady,
    input  fifoPop, txValid, txData, txTag, txByteEn, txEop, txSop
  );
endinterface

// File: rtl/fifo_pop_streamer.sv
// Pops FWFT FIFO entries, checks sop/eop framing and streams accepted beats
// through a 2-entry in-order output buffer.
//
// state  | meaning
// IDLE   | between packets; next popped entry must carry sop
// IN_PKT | inside a packet; next popped entry continues it (sop here truncates)
module fifo_pop_streamer #(
  parameter int CNT_W = 16
) (
  input  logic                  clockCore,
  input  logic                  resetCore,
  fifo_pop_streamer_if.master   bus,
  output logic [CNT_W-1:0]      pktCount,
  output logic                  frameErr,
  output logic [7:0]            frameErrCount,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t      stateCur;
  state_t      stateNxt;
  logic [83:0] buf0;
  logic [83:0] buf1;
  logic [1:0]  bufCount;
  logic        entrySop;
  logic        entryEop;
  logic        accept;
  logic        doPop;
  logic        doFwd;
  logic        doErr;

  assign entrySop = bus.fifoDataOut[83];
  assign entryEop = bus.fifoDataOut[82];

  always_ff @(posedge clockCore) begin
    if (!resetCore) stateCur <= IDLE;
    else            stateCur <= stateNxt;
  end

  always_comb begin
    stateNxt = stateCur;
    if (doPop) begin
      if ((entrySop || stateCur == IN_PKT) && !entryEop) stateNxt = IN_PKT;
      else                                               stateNxt = IDLE;
    end
  end

  // A pop is allowed whenever the buffer has room now or frees a slot this edge.
  always_comb begin
    accept = (bufCount != 2'd0) && bus.txReady;
    doPop  = !bus.fifoEmpty && resetCore && ((bufCount < 2'd2) || accept);
    doFwd  = doPop && (entrySop || stateCur == IN_PKT);
    doErr  = doPop && (entrySop == (stateCur == IN_PKT));
    busy   = (stateCur == IN_PKT) || (bufCount != 2'd0);
  end

  assign bus.fifoPop  = doPop;
  assign bus.txValid  = (bufCount != 2'd0);
  assign bus.txData   = buf0[63:0];
  assign bus.txTag    = buf0[73:64];
  assign bus.txByteEn = buf0[81:74];
  assign bus.txEop    = buf0[82];
  assign bus.txSop    = buf0[83];

  always_ff @(posedge clockCore) begin
    if (!resetCore) begin
      buf0     <= '0;
      buf1     <= '0;
      bufCount <= 2'd0;
    end else begin
      case ({doFwd, accept})
        2'b10: begin
          if (bufCount == 2'd0) buf0 <= bus.fifoDataOut;
          else                  buf1 <= bus.fifoDataOut;
          bufCount <= bufCount + 2'd1;
        end
        2'b01: begin
          buf0     <= buf1;
          buf1     <= '0;
          bufCount <= bufCount - 2'd1;
        end
        2'b11: begin
          if (bufCount == 2'd1) begin
            buf0 <= bus.fifoDataOut;
          end else begin
            buf0 <= buf1;
            buf1 <= bus.fifoDataOut;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clockCore) begin
    if (!resetCore) begin
      pktCount      <= '0;
      frameErr      <= 1'b0;
      frameErrCount <= 8'd0;
    end else begin
      frameErr <= doErr;
      if (doFwd && entryEop) pktCount <= pktCount + 1'b1;
      if (doErr && frameErrCount != 8'hFF) frameErrCount <= frameErrCount + 8'd1;
    end
  end

endmodule
